mem_responder: RTL

//   Memory-side responder for the CPU's data/instruction port; the CPU is the initiator.

---
 rtl/mem_responder.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/mem_responder.sv
// mem_responder: single-outstanding word memory responder for the CPU port.
// A request is accepted in IDLE, waits WAIT_CYCLES states, then answers with a
// one-cycle ready pulse (err flags out-of-range addresses). A side-band load
// port fills the array while the responder is idle and no request is pending.
module mem_responder #(
  parameter int ADDR_W      = 5,
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 32,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              ready,
  output logic              err,
  output logic              busy,
  input  logic              ld_en,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  output logic              ld_done
);

  localparam int CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WAIT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t            state_r, state_s;
  logic [CNT_W-1:0]  cnt_r, cnt_s;
  logic              accept_s, load_s, enter_resp_s;
  logic              we_r;
  logic [ADDR_W-1:0] addr_r;
  logic [DATA_W-1:0] wdata_r;
  logic              txn_we_s;
  logic [ADDR_W-1:0] txn_addr_s;
  logic [DATA_W-1:0] txn_wdata_s;
  logic              txn_in_range_s, ld_in_range_s;
  logic [IDX_W-1:0]  txn_idx_s, ld_idx_s, mem_idx_s;
  logic              mem_we_s;
  logic [DATA_W-1:0] mem_wdata_s;
  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [DATA_W-1:0] rdata_r;
  logic              ready_r, err_r, busy_r, ld_done_r;

  // True when a word address maps onto an implemented array entry.
  function automatic logic addr_in_range(input logic [ADDR_W-1:0] a);
    return (int'(a) < DEPTH);
  endfunction

  // State register and wait counter; reset abandons any transaction in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
      cnt_r   <= {CNT_W{1'b0}};
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
    end
  end

  // Next-state logic: accept in IDLE (req beats ld_en), count down in WAIT, one RESP cycle.
  always_comb begin
    state_s  = state_r;
    cnt_s    = cnt_r;
    accept_s = 1'b0;
    load_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (req) begin
          accept_s = 1'b1;
          cnt_s    = CNT_INIT;
          state_s  = (WAIT_CYCLES == 0) ? ST_RESP : ST_WAIT;
        end else if (ld_en) begin
          load_s = 1'b1;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt_r == CNT_ONE) begin
          state_s = ST_RESP;
          cnt_s   = {CNT_W{1'b0}};
        end else begin
          cnt_s = cnt_r - CNT_ONE;
        end
      end
      ST_RESP: state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // Request latch; captured only on the accept edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_r    <= 1'b0;
      addr_r  <= {ADDR_W{1'b0}};
      wdata_r <= {DATA_W{1'b0}};
    end else if (accept_s) begin
      we_r    <= we;
      addr_r  <= addr;
      wdata_r <= wdata;
    end
  end

  // Operands of the transaction reaching RESP: live inputs when coming straight from IDLE.
  always_comb begin
    if (state_r == ST_IDLE) begin
      txn_we_s    = we;
      txn_addr_s  = addr;
      txn_wdata_s = wdata;
    end else begin
      txn_we_s    = we_r;
      txn_addr_s  = addr_r;
      txn_wdata_s = wdata_r;
    end
  end

  assign enter_resp_s   = (state_s == ST_RESP);
  assign txn_in_range_s = addr_in_range(txn_addr_s);
  assign ld_in_range_s  = addr_in_range(ld_addr);
  assign txn_idx_s      = txn_addr_s[IDX_W-1:0];
  assign ld_idx_s       = ld_addr[IDX_W-1:0];

  // Single array write port shared by committed writes and loads; never during reset.
  always_comb begin
    mem_we_s    = 1'b0;
    mem_idx_s   = txn_idx_s;
    mem_wdata_s = txn_wdata_s;
    if (load_s) begin
      mem_we_s    = ld_in_range_s && !rst;
      mem_idx_s   = ld_idx_s;
      mem_wdata_s = ld_data;
    end else begin
      mem_we_s = enter_resp_s && txn_we_s && txn_in_range_s && !rst;
    end
  end

  // Storage array; deliberately not reset.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem_r[mem_idx_s] <= mem_wdata_s;
    end
  end

  // Registered response outputs; rdata only moves on a read response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_r   <= {DATA_W{1'b0}};
      ready_r   <= 1'b0;
      err_r     <= 1'b0;
      busy_r    <= 1'b0;
      ld_done_r <= 1'b0;
    end else begin
      ready_r   <= enter_resp_s;
      err_r     <= enter_resp_s && !txn_in_range_s;
      busy_r    <= (state_s != ST_IDLE);
      ld_done_r <= load_s;
      if (enter_resp_s && !txn_we_s) begin
        rdata_r <= txn_in_range_s ? mem_r[txn_idx_s] : {DATA_W{1'b0}};
      end
    end
  end

  assign rdata   = rdata_r;
  assign ready   = ready_r;
  assign err     = err_r;
  assign busy    = busy_r;
  assign ld_done = ld_done_r;

endmodule
